// File: rtl/xb_wr_framer.sv
// Xillybus write-stream framer: strips a magic/length header, forwards payload
// words to the write FIFO with one cycle of latency, and keeps frame statistics.
module xb_wr_framer #(
  parameter int          WIDTH = 32,
  parameter logic [15:0] MAGIC = 16'hB10C,
  parameter int          DELAY = 1
) (
  input  logic             BUS_CLK,
  input  logic             RESET,
  input  logic             xb_wr_open,
  input  logic             xb_wr_wren,
  input  logic [WIDTH-1:0] xb_wr_data,
  output logic             xb_wr_full,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_wren,
  input  logic             fifo_almost_full,
  output logic             frame_done,
  output logic             frame_err,
  output logic [15:0]      n_frame,
  output logic [31:0]      n_word
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] remaining;
  logic [15:0] remaining_next;
  logic        fwd;
  logic        done_set;
  logic        err_set;
  logic        err_clr;
  logic        last_word;
  logic [15:0] hdr_magic;
  logic [15:0] hdr_len;

  // DELAY only matters to behavioural models of this block; these registers are zero-delay.
  if (DELAY < 0) begin : g_delay_unused
  end

  assign hdr_magic = xb_wr_data[31:16];
  assign hdr_len   = xb_wr_data[15:0];
  assign last_word = xb_wr_wren && (remaining == 16'd1);

  // In ERR the host must be able to drain its stream, so backpressure is dropped.
  assign xb_wr_full = RESET | ((state != ERR) & fifo_almost_full);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    fwd            = 1'b0;
    done_set       = 1'b0;
    err_set        = 1'b0;
    err_clr        = 1'b0;

    case (state)
      IDLE: begin
        if (xb_wr_wren) begin
          if (hdr_magic == MAGIC) begin
            err_clr = 1'b1;
            if (hdr_len == 16'd0) begin
              done_set = 1'b1;
            end else begin
              remaining_next = hdr_len;
              state_next     = PAYLOAD;
            end
          end else begin
            err_set    = 1'b1;
            state_next = ERR;
          end
        end
      end

      PAYLOAD: begin
        if (xb_wr_wren) begin
          fwd            = 1'b1;
          remaining_next = remaining - 16'd1;
          if (last_word) begin
            done_set   = 1'b1;
            state_next = IDLE;
          end
        end
        // A stream closing on the very word that completes the frame is not a truncation.
        if (!xb_wr_open && !last_word) begin
          err_set        = 1'b1;
          remaining_next = 16'd0;
          state_next     = IDLE;
        end
      end

      ERR: begin
        if (!xb_wr_open) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge BUS_CLK) begin
    if (RESET) begin
      state     <= IDLE;
      remaining <= 16'd0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RESET) begin
      fifo_wren  <= 1'b0;
      fifo_din   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      n_frame    <= 16'd0;
      n_word     <= 32'd0;
    end else begin
      fifo_wren  <= fwd;
      frame_done <= done_set;
      if (fwd) begin
        fifo_din <= xb_wr_data;
        n_word   <= n_word + 32'd1;
      end
      if (done_set) begin
        n_frame <= n_frame + 16'd1;
      end
      if (err_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule
